// File: rtl/matmul_tile_ctrl.sv
// Tiled matrix-multiply sequencer: fetches A/B tiles per (m,n,k), feeds a registered
// operand pair to an external combinational datapath, and accumulates with saturation.
module matmul_tile_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_R     = 8,
  parameter int TILE_K     = 4,
  parameter int TILE_C     = 8,
  parameter int K_TILES    = 4,
  parameter int M_TILES    = 2,
  parameter int N_TILES    = 2,
  localparam int MW = (M_TILES > 1) ? $clog2(M_TILES) : 1,
  localparam int NW = (N_TILES > 1) ? $clog2(N_TILES) : 1,
  localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1,
  localparam int AW = DATA_WIDTH * TILE_R * TILE_K,
  localparam int BW = DATA_WIDTH * TILE_K * TILE_C,
  localparam int OW = DATA_WIDTH * TILE_R * TILE_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [MW-1:0] req_m,
  output logic [NW-1:0] req_n,
  output logic [KW-1:0] req_k,
  input  logic          tile_valid,
  input  logic [AW-1:0] a_tile,
  input  logic [BW-1:0] b_tile,
  output logic [AW-1:0] mm_in_1,
  output logic [BW-1:0] mm_in_2,
  input  logic [OW-1:0] mm_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_m,
  output logic [NW-1:0] out_n,
  output logic [OW-1:0] out_tile
);

  localparam int NE = TILE_R * TILE_C;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [MW-1:0] M_LAST = MW'(M_TILES - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_TILES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K_TILES - 1);

  logic [2:0]    state;
  logic [MW-1:0] m_cnt;
  logic [NW-1:0] n_cnt;
  logic [KW-1:0] k_cnt;
  logic [OW-1:0] acc;
  logic [OW-1:0] acc_next;

  // Signed add one bit wider than an element, clamped to the element's signed range.
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y);
    logic [DATA_WIDTH:0] s;
    s = {x[DATA_WIDTH-1], x} + {y[DATA_WIDTH-1], y};
    if (s[DATA_WIDTH] == s[DATA_WIDTH-1]) return s[DATA_WIDTH-1:0];
    else if (s[DATA_WIDTH])               return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                                  return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload hold steady until then and ready never feeds back into valid.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign req_valid = (state == S_REQ);
  assign out_valid = (state == S_OUT);
  assign req_m     = m_cnt;
  assign req_n     = n_cnt;
  assign req_k     = k_cnt;
  assign out_m     = m_cnt;
  assign out_n     = n_cnt;
  assign out_tile  = acc;

  // First inner tile overwrites the accumulator so no separate clear cycle is needed.
  always_comb begin
    acc_next = acc;
    for (int e = 0; e < NE; e++) begin
      if (k_cnt == '0)
        acc_next[e*DATA_WIDTH +: DATA_WIDTH] = mm_out[e*DATA_WIDTH +: DATA_WIDTH];
      else
        acc_next[e*DATA_WIDTH +: DATA_WIDTH] = sat_add(acc[e*DATA_WIDTH +: DATA_WIDTH],
                                                       mm_out[e*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      m_cnt   <= '0;
      n_cnt   <= '0;
      k_cnt   <= '0;
      mm_in_1 <= '0;
      mm_in_2 <= '0;
      acc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_cnt <= '0;
            n_cnt <= '0;
            k_cnt <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (tile_valid) begin
            mm_in_1 <= a_tile;
            mm_in_2 <= b_tile;
            state   <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= acc_next;
          if (k_cnt == K_LAST) begin
            state <= S_OUT;
          end else begin
            k_cnt <= k_cnt + KW'(1);
            state <= S_REQ;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            k_cnt <= '0;
            if (n_cnt == N_LAST) begin
              n_cnt <= '0;
              m_cnt <= m_cnt + MW'(1);
            end else begin
              n_cnt <= n_cnt + NW'(1);
            end
            state <= (m_cnt == M_LAST && n_cnt == N_LAST) ? S_DONE : S_REQ;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Self-checking bench: random handshake timing and operands, a job-level reference model
// of tile order, accumulation and saturation, plus literal results for known operands.
module tb_matmul_tile_ctrl;

  localparam int DW = 16, TR = 8, TK = 4, TC = 8, KT = 4, MT = 2, NT = 2;
  localparam int AW = DW * TR * TK, BW = DW * TK * TC, OW = DW * TR * TC, NE = TR * TC;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          busy, done, req_valid, out_valid;
  logic          req_ready = 1'b0, tile_valid = 1'b0, out_ready = 1'b0;
  logic [0:0]    req_m, req_n, out_m, out_n;
  logic [1:0]    req_k;
  logic [AW-1:0] a_tile = '0, mm_in_1;
  logic [BW-1:0] b_tile = '0, mm_in_2;
  logic [OW-1:0] mm_out, out_tile;

  int n_cmp = 0, n_err = 0;

  matmul_tile_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_n(req_n), .req_k(req_k),
    .tile_valid(tile_valid), .a_tile(a_tile), .b_tile(b_tile),
    .mm_in_1(mm_in_1), .mm_in_2(mm_in_2), .mm_out(mm_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_m(out_m), .out_n(out_n), .out_tile(out_tile)
  );

  always #5 clk = ~clk;

  // Q8.8 matrix product standing in for the external combinational datapath.
  function automatic logic [OW-1:0] dp(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [39:0] s;
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < TR; i++)
      for (int j = 0; j < TC; j++) begin
        s = '0;
        for (int q = 0; q < TK; q++)
          s = s + $signed(a[(i*TK+q)*DW +: DW]) * $signed(b[(q*TC+j)*DW +: DW]);
        s = s >>> 8;
        r[(i*TC+j)*DW +: DW] = s[DW-1:0];
      end
    return r;
  endfunction

  assign mm_out = dp(mm_in_1, mm_in_2);

  function automatic logic [15:0] sat_ref(input int x);
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    int bad;
    bad = -1;
    n_cmp++;
    for (int e = NE - 1; e >= 0; e--)
      if (act[e*DW +: DW] !== exp[e*DW +: DW]) bad = e;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: element %0d got %h want %h", name, bad, act[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  bit               zero_wait = 0, lit_on = 0;
  logic [15:0]      lit_val = '0;
  int               req_q[$];
  int               oidx_q[$];
  logic [OW-1:0]    exp_q[$];
  logic signed [15:0] macc [NE];
  int               mk = 0, tiles_done = 0, cyc = 0, last_evt = 0;
  bit               m_wait = 0, exp_busy = 0, exp_done = 0, nb, nd, out_fire;
  bit               p_req_hold = 0, p_out_hold = 0;
  logic [3:0]       p_req_idx;
  logic [1:0]       p_out_idx;
  logic [OW-1:0]    p_out_tile, mon_p, mon_t;
  logic [AW-1:0]    mm1_exp = '0;
  logic [BW-1:0]    mm2_exp = '0;
  logic signed [15:0] pe;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_busy = 0; exp_done = 0; m_wait = 0; mk = 0; tiles_done = 0;
      p_req_hold = 0; p_out_hold = 0; mm1_exp = '0; mm2_exp = '0;
      req_q.delete(); oidx_q.delete(); exp_q.delete();
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset req_valid", 64'(req_valid), 64'd0);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset mm_in/acc zero", 64'(|{mm_in_1, mm_in_2, out_tile}), 64'd0);
      chk("reset indices zero", 64'({req_m, req_n, req_k, out_m, out_n}), 64'd0);
    end else begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk_tile("mm_in_1", OW'(mm_in_1), OW'(mm1_exp));
      chk_tile("mm_in_2", OW'(mm_in_2), OW'(mm2_exp));
      if (out_valid) chk("no request while output pending", 64'(req_valid), 64'd0);
      if (!exp_busy) chk("idle valids", 64'({req_valid, out_valid}), 64'd0);
      if (p_req_hold) chk("req held", 64'({req_valid, req_m, req_n, req_k}), 64'({1'b1, p_req_idx}));
      if (p_out_hold) begin
        chk("out held", 64'({out_valid, out_m, out_n}), 64'({1'b1, p_out_idx}));
        chk_tile("out_tile held", out_tile, p_out_tile);
      end
      // tile capture precedes the request check so one cycle never does both
      if (m_wait && tile_valid) begin
        mon_p = dp(a_tile, b_tile);
        for (int e = 0; e < NE; e++) begin
          pe = mon_p[e*DW +: DW];
          macc[e] = (mk == 0) ? pe : sat_ref(int'(macc[e]) + int'(pe));
        end
        mk++;
        if (mk == KT) begin
          for (int e = 0; e < NE; e++) mon_t[e*DW +: DW] = macc[e];
          exp_q.push_back(mon_t);
          mk = 0;
        end
        mm1_exp = a_tile; mm2_exp = b_tile; m_wait = 0;
      end
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) chk("unexpected request", 64'd1, 64'd0);
        else chk("request index", 64'({req_m, req_n, req_k}), 64'(req_q.pop_front()));
        m_wait = 1;
      end
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) chk("unexpected output", 64'd1, 64'd0);
        else begin
          mon_t = exp_q.pop_front();
          chk_tile("out_tile", out_tile, mon_t);
          if (lit_on) begin
            chk_tile("out_tile literal", out_tile, {NE{lit_val}});
            chk_tile("model literal", mon_t, {NE{lit_val}});
          end
        end
        if (oidx_q.size() == 0) chk("unexpected output index", 64'd1, 64'd0);
        else chk("output index", 64'({out_m, out_n}), 64'(oidx_q.pop_front()));
        if (zero_wait) chk("tile latency", 64'(cyc - last_evt), 64'(3 * KT + 1));
        last_evt = cyc;
        tiles_done++;
      end
      nb = exp_busy; nd = 0;
      if (exp_done) nb = 0;
      else if (!exp_busy && start) begin
        nb = 1; mk = 0; m_wait = 0; tiles_done = 0; last_evt = cyc;
        req_q.delete(); oidx_q.delete(); exp_q.delete();
        for (int m = 0; m < MT; m++)
          for (int n = 0; n < NT; n++) begin
            oidx_q.push_back(m * NT + n);
            for (int k = 0; k < KT; k++) req_q.push_back((m * NT + n) * KT + k);
          end
      end
      if (out_fire && tiles_done == MT * NT) nd = 1;
      exp_busy = nb; exp_done = nd;
      p_req_hold = req_valid && !req_ready;
      p_req_idx  = {req_m, req_n, req_k};
      p_out_hold = out_valid && !out_ready;
      p_out_idx  = {out_m, out_n};
      p_out_tile = out_tile;
    end
  end

  // ---------------- driver ----------------
  task automatic rand_tiles();
    for (int w = 0; w < AW / 32; w++) a_tile[w*32 +: 32] = $urandom();
    for (int w = 0; w < BW / 32; w++) b_tile[w*32 +: 32] = $urandom();
  endtask

  task automatic run_job(input int rlo, input int rhi, input int tlo, input int thi,
                         input int olo, input int ohi, input bit cdata,
                         input logic [15:0] av, input logic [15:0] bv,
                         input bit junk_start, input bit abort,
                         input bit lit, input logic [15:0] lval);
    bit   fr, ft, awaiting = 0, rv_p = 0, rr_p = 0, tv_p = 0, seen_done = 0;
    int   rc = 0, rd = 0, tc = 0, td = 0, oc = 0, od = 0;
    logic [3:0] idx_p = '0;
    zero_wait = (rhi == 0 && thi == 0 && ohi == 0);
    lit_on = lit; lit_val = lval;
    @(posedge clk); #1;
    start = 1'b1;
    for (int cy = 0; cy < 3000 && !seen_done; cy++) begin
      @(posedge clk); #1;
      fr = rv_p && rr_p;
      ft = tv_p && awaiting;
      if (ft) awaiting = 0;
      if (fr) begin awaiting = 1; tc = 0; td = $urandom_range(thi, tlo); end
      if (abort && fr && idx_p == 4'b1000) begin
        rst = 1'b1; #1;
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset valids", 64'({req_valid, out_valid, done}), 64'd0);
        chk("async reset operands", 64'(|{mm_in_1, mm_in_2, out_tile}), 64'd0);
        start = 0; req_ready = 0; tile_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (done) seen_done = 1;
      start = junk_start && ($urandom_range(0, 9) == 0);
      if (req_valid) begin
        if (rc == 0) rd = $urandom_range(rhi, rlo);
        req_ready = (rc >= rd); rc++;
      end else begin
        rc = 0; req_ready = 1'($urandom_range(0, 1));
      end
      if (awaiting) begin
        tile_valid = (tc >= td); tc++;
        if (cdata) begin a_tile = {(TR*TK){av}}; b_tile = {(TK*TC){bv}}; end
        else rand_tiles();
      end else begin
        tile_valid = req_valid || ($urandom_range(0, 3) == 0);
        rand_tiles();
      end
      if (out_valid) begin
        if (oc == 0) od = $urandom_range(ohi, olo);
        out_ready = (oc >= od); oc++;
      end else begin
        oc = 0; out_ready = 1'($urandom_range(0, 1));
      end
      rv_p = req_valid; rr_p = req_ready; tv_p = tile_valid; idx_p = {req_m, req_n, req_k};
    end
    start = 0; req_ready = 0; tile_valid = 0; out_ready = 0;
    chk("job reached done", 64'(seen_done), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // unity operands, zero-wait handshakes
    run_job(0, 0, 0, 0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 1, 16'h1000);
    // positive saturation on the second inner tile
    run_job(0, 0, 0, 0, 0, 0, 1, 16'h1000, 16'h0100, 0, 0, 1, 16'h7FFF);
    // negative: exactly 0x8000 after two tiles, then clamped
    run_job(0, 0, 0, 0, 0, 0, 1, 16'hF000, 16'h0100, 0, 0, 1, 16'h8000);
    // request stalled 5 cycles, output stalled 3 cycles
    run_job(5, 5, 0, 0, 3, 3, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    // abort in WAIT of tile (1,0)
    run_job(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
    repeat (4) @(posedge clk);
    // restart with stray start/tile_valid pulses
    run_job(0, 0, 0, 0, 0, 0, 1, 16'h0100, 16'h0100, 1, 0, 1, 16'h1000);
    for (int j = 0; j < 4; j++)
      run_job(0, 3, 0, 3, 0, 3, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0);
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matmul_tile_ctrl.md
MATMUL_TILE_CTRL -- requirements
Module: matmul_tile_ctrl

Interface
- REQ-001 The parameters SHALL be:
  - DATA_WIDTH, 16, signed fixed-point element width (upper half integer, lower half fraction).
  - TILE_R, 8, rows per tile.
  - TILE_K, 4, inner dimension per tile.
  - TILE_C, 8, columns per tile.
  - K_TILES, 4, inner-dimension tiles per output tile.
  - M_TILES, 2, output tile rows.
  - N_TILES, 2, output tile columns.
- REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
- REQ-003 The ports SHALL be:
  - clk  in  1  clock.
  - rst  in  1  async active-high reset.
  - start  in  1  begin full matrix job.
  - busy  out  1  job in progress.
  - done  out  1  one-cycle pulse at job end.
  - req_valid  out  1  tile fetch request.
  - req_ready  in  1  fetch accepted.
  - req_m  out  clog2(M_TILES)  tile row index.
  - req_n  out  clog2(N_TILES)  tile column index.
  - req_k  out  clog2(K_TILES)  inner tile index.
  - tile_valid  in  1  fetched operands present.
  - a_tile  in  DATA_WIDTH*TILE_R*TILE_K  A tile, row-major, element (0,0) in LSBs.
  - b_tile  in  DATA_WIDTH*TILE_K*TILE_C  B tile, row-major.
  - mm_in_1  out  DATA_WIDTH*TILE_R*TILE_K  registered A operand to the combinational matmul datapath.
  - mm_in_2  out  DATA_WIDTH*TILE_K*TILE_C  registered B operand to the datapath.
  - mm_out  in  DATA_WIDTH*TILE_R*TILE_C  datapath product, row-major.
  - out_valid  out  1  output tile available.
  - out_ready  in  1  consumer accepts.
  - out_m  out  clog2(M_TILES)  output tile row index.
  - out_n  out  clog2(N_TILES)  output tile column index.
  - out_tile  out  DATA_WIDTH*TILE_R*TILE_C  accumulated result tile.

Function
- REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT, ACC, OUT and DONE.
- REQ-005 In IDLE, start=1 SHALL clear the m, n and k counters, and the next state SHALL be REQ; start SHALL be ignored in all other states.
- REQ-006 busy SHALL be 1 in every state except IDLE.
- REQ-007 In REQ, req_valid SHALL be 1 with req_m/n/k equal to the current counters, held stable until req_ready=1; a REQ cycle with req_ready=1 SHALL move the FSM to WAIT.
- REQ-008 In WAIT, tile_valid=1 SHALL capture a_tile into mm_in_1 and b_tile into mm_in_2, and the FSM SHALL move to ACC; tile_valid in any other state SHALL be ignored.
- REQ-009 In ACC (one cycle), each accumulator element SHALL load mm_out when k=0, else load sat(acc + mm_out).
- REQ-010 sat() SHALL be a DATA_WIDTH+1-bit signed add clamped to 0x7FFF..0x8000 (for DATA_WIDTH=16).
- REQ-011 From ACC, if k=K_TILES-1 the FSM SHALL go to OUT; otherwise k SHALL increment and the FSM SHALL return to REQ.
- REQ-012 In OUT, out_valid SHALL be 1, with out_tile, out_m and out_n held stable until out_ready=1.
- REQ-013 On OUT with out_ready=1, k SHALL reset to 0 and n SHALL increment; at n=N_TILES-1, n SHALL wrap to 0 and m SHALL increment.
- REQ-014 On OUT with out_ready=1, the FSM SHALL go to DONE if m=M_TILES-1 and n=N_TILES-1, else to REQ.
- REQ-015 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
- REQ-016 Per output tile, latency SHALL be K_TILES*(REQ+WAIT+ACC) plus the OUT cycles; with zero-wait handshakes this is 3*K_TILES+1 cycles.
- REQ-017 mm_in_1 and mm_in_2 SHALL change only on the WAIT capture, so the datapath input is stable through ACC.
- REQ-018 Under out_ready backpressure, no new request SHALL issue until the tile is accepted.

Reset
- REQ-019 On rst=1, the FSM SHALL enter IDLE asynchronously.
- REQ-020 On rst=1, busy, done, req_valid and out_valid SHALL be 0.
- REQ-021 On rst=1, all counters, mm_in_1, mm_in_2 and the accumulator SHALL be 0.
- REQ-022 Reset asserted mid-job SHALL abort the job with no done pulse; after release the block SHALL wait for a new start.

Verification
- REQ-023 A all 0x0100, B all 0x0100, req_ready and tile_valid returned next cycle, out_ready=1 -> 4 output tiles, every element 0x1000, done after the last.
- REQ-024 A all 0x1000, B all 0x0100 (mm_out 0x4000) -> the second accumulation saturates; all elements 0x7FFF.
- REQ-025 A all 0xF000, B 0x0100 -> -128 gives 0x8000 after 2 tiles and stays 0x8000 after 4; no wrap to positive.
- REQ-026 req_ready held 0 for 5 cycles, then out_ready held 0 for 3 cycles -> req_*/out_* stable throughout, no extra requests, and the index order is (0,0),(0,1),(1,0),(1,1).
- REQ-027 rst pulsed during WAIT of tile (1,0) -> all outputs go to 0 immediately, no done pulse; a new start replays from (0,0,0).
- REQ-028 start pulsed while busy, and tile_valid pulsed in REQ -> no effect; results identical to REQ-023.
